instr_prefetch_queue: RTL
=========================

// Module: instr_prefetch_queue
// PURPOSE
//  Parametrised successor to the single-entry instruction register: a DEPTH-entry FIFO of fetched
//  instructions, each stored with its PC, between instruction memory and decode.
//  Valid/ready on both sides; flush discards queued entries on branch/jump redirect.
//  Head entry is pre-split into MIPS-style fields so decode needs no extra slicing.
// PARAMETERS
//  DATA_W   32  instruction width (>=32; fields taken from bits [31:0])
//  ADDR_W   32  PC width stored alongside each instruction
//  DEPTH    4   entries; power of two, >=2
//  CNT_W    $clog2(DEPTH)+1  occupancy counter width (derived, not overridden)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  flush      in   1       discard all entries this cycle
//  in_valid   in   1       fetch side presents in_instr/in_pc
//  in_ready   out  1       queue accepts push (= !full)
//  in_instr   in   DATA_W  fetched instruction
//  in_pc      in   ADDR_W  PC of in_instr
//  out_valid  out  1       head entry valid (= !empty)
//  out_ready  in   1       decode consumes head
//  out_instr  out  DATA_W  head instruction; 0 when empty
//  out_pc     out  ADDR_W  head PC; 0 when empty
//  out_opcode out  6       out_instr[31:26]
//  out_rs/out_rt/out_rd out 5 each  [25:21]/[20:16]/[15:11]
//  out_imm    out  16      out_instr[15:0]
//  count      out  CNT_W   current occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset: reset synchronous, active-high; clock clk. Pointers and count -> 0; out_valid=0,
//    in_ready=1, out_instr/out_pc/fields=0. Storage array not cleared.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Both qualified same edge.
//  - Push: mem[wr_ptr] <= {in_pc,in_instr}; wr_ptr++ mod DEPTH. Pop: rd_ptr++ mod DEPTH.
//  - count: +1 push only, -1 pop only, unchanged on both or neither. Never exceeds DEPTH, never <0.
//  - Latency (macro off): pushed word visible at out_* the cycle after the push edge.
//  - Full (count==DEPTH): in_ready=0, so push blocked even if pop occurs same cycle.
//  - Empty: out_valid=0, out_* and fields forced 0; out_ready ignored.
//  - Flush: priority over push and pop; rd_ptr<=wr_ptr, count<=0; push that cycle dropped.
//  - Reset priority over flush. Reset or flush mid-stream loses queued entries, no partial state.
//  - in_ready/out_valid/out_* are registered-state functions only (no comb path from in_* to
//    out_*) unless the bypass macro is defined.
//  - Field outputs are pure slices of out_instr; no sign extension here.
// CONFIGURATION
//  IPQ_BYPASS_EN defined: when count==0 and in_valid and !flush, out_valid=1 and out_* = in_*
//    combinationally; if out_ready same cycle, word consumed and not written (count stays 0).
//    If not consumed, written normally. Zero-latency fall-through.
//  Undefined: no in->out comb path; minimum latency 1 cycle as above.
// STRUCTURE
//  Shared package cpu_pkg: OPCODE_W=6, REG_W=5, IMM_W=16, field bit positions, IPQ_DEPTH default.
//  One sub-module natural: ipq_storage (DEPTH x (ADDR_W+DATA_W) register array, one write port,
//  one async read port). Pointer/count control and field slicing stay in top.
// TESTING
//  1 Reset, idle: out_valid=0, in_ready=1, count=0, out_instr=0.
//  2 Push 0x8C220004@pc0x0 .. 4 words, out_ready=0 -> count=4, in_ready=0; 5th push ignored;
//    head out_instr=0x8C220004, opcode=0x23, rs=1, rt=2, imm=0x0004.
//  3 Full + out_ready=1 + in_valid=1 -> pop only, count 4->3; next cycle push accepted, count=4.
//  4 count=2, push+pop same cycle -> count stays 2, order preserved (FIFO order check vs model).
//  5 count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, pushed word lost.
//  6 Macro on, empty, in_valid=1, in_instr=0x00851020, out_ready=1 -> out_valid=1 same cycle,
//    rd=2, count remains 0; macro off same stimulus -> out_valid=0 that cycle, 1 next.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: instruction field geometry and prefetch queue defaults.
package cpu_pkg;

    localparam int OPCODE_W  = 6;
    localparam int REG_W     = 5;
    localparam int IMM_W     = 16;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int IMM_LSB    = 0;

    localparam int IPQ_DEPTH  = 4;

endpackage

// File: rtl/ipq_storage.sv
// Prefetch queue entry array: one write port, one asynchronous read port.
module ipq_storage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = IPQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO with PC, flush and pre-split head fields.
// Optional zero-latency fall-through when IPQ_BYPASS_EN is defined.
module instr_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = IPQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_instr,
    input  logic [ADDR_W-1:0]   in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_instr,
    output logic [ADDR_W-1:0]   out_pc,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [REG_W-1:0]    out_rs,
    output logic [REG_W-1:0]    out_rt,
    output logic [REG_W-1:0]    out_rd,
    output logic [IMM_W-1:0]    out_imm,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [ENT_W-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             push;
    logic             bypass;
    logic             take;
    logic             wr_en;
    logic             rd_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));

`ifdef IPQ_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = ~full;
    assign out_valid = ~empty | bypass;
    assign push      = in_valid & in_ready;
    // A fall-through word consumed the same cycle never enters the array.
    assign take      = bypass & out_ready;
    assign wr_en     = push & ~take & ~flush;
    assign rd_en     = ~empty & out_ready & ~flush;
    assign count     = cnt_q;

    ipq_storage #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({in_pc, in_instr}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end else if (!empty) begin
            out_instr = rd_data[DATA_W-1:0];
            out_pc    = rd_data[ENT_W-1:DATA_W];
        end
    end

    assign out_opcode = out_instr[OPCODE_LSB +: OPCODE_W];
    assign out_rs     = out_instr[RS_LSB +: REG_W];
    assign out_rt     = out_instr[RT_LSB +: REG_W];
    assign out_rd     = out_instr[RD_LSB +: REG_W];
    assign out_imm    = out_instr[IMM_LSB +: IMM_W];

endmodule
